// File: rtl/ula_pkg.sv
// Shared constants for the ula add/subtract unit.
package ula_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/ula_if.sv
// Operand/result bundle between the operand source and the ula.
interface ula_if #(
  parameter int WIDTH = 4
);
  logic             sel;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic [WIDTH-1:0] output_s;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output sel, input_a, input_b,
    input  output_s, carry, ovf, zero, neg
  );

  modport slave (
    input  sel, input_a, input_b,
    output output_s, carry, ovf, zero, neg
  );
endinterface

// File: rtl/ula_addsub_core.sv
// Combinational shared adder: B is inverted and carry-in set for subtract.
module ula_addsub_core
  import ula_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);
  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  // One adder serves both ops; subtract is A + ~B + 1.
  always_comb begin
    sub   = (sel == OP_SUB);
    b_eff = b ^ {WIDTH{sub}};
    full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum   = full[WIDTH-1:0];
    carry = full[WIDTH];
    // Signed overflow: adder operands agree in sign but the result does not.
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end
endmodule

// File: rtl/ula.sv
// Registered add/subtract unit with carry/overflow/zero/negative flags.
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  ula_if.slave  bus
);
  logic [WIDTH-1:0] sum;
  logic             core_carry;
  logic             core_ovf;

  logic [WIDTH-1:0] output_s_d, output_s_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;
  logic             neg_d, neg_q;

  ula_addsub_core #(.WIDTH(WIDTH)) u_core (
    .a     (bus.input_a),
    .b     (bus.input_b),
    .sel   (bus.sel),
    .sum   (sum),
    .carry (core_carry),
    .ovf   (core_ovf)
  );

  // Next-state: core result plus flags derived from the result itself.
  always_comb begin
    output_s_d = sum;
    carry_d    = core_carry;
    ovf_d      = core_ovf;
    zero_d     = (sum == '0);
    neg_d      = sum[WIDTH-1];
  end

  // Output register; reset clears the result, so zero reads as set.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_s_q <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b1;
      neg_q      <= 1'b0;
    end else begin
      output_s_q <= output_s_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
    end
  end

  assign bus.output_s = output_s_q;
  assign bus.carry    = carry_q;
  assign bus.ovf      = ovf_q;
  assign bus.zero     = zero_q;
  assign bus.neg      = neg_q;
endmodule

// File: tb/tb_ula.sv
// Randomised bench for ula against an integer-arithmetic reference model.
module tb_ula;
  import ula_pkg::*;
  localparam int W = 4;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  ula_if #(.WIDTH(W)) bus ();

  ula #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one operation, let one edge pass, compare against the model.
  task automatic op(input bit r, input bit s, input int a, input int b);
    int ua, ub, sa, sb, res, sres;
    int e_s, e_c, e_o, e_z, e_n;
    ua = a % M;
    ub = b % M;
    sa = (ua >= M/2) ? ua - M : ua;
    sb = (ub >= M/2) ? ub - M : ub;
    if (s == OP_ADD) begin
      res  = ua + ub;
      sres = sa + sb;
      e_c  = (res >= M) ? 1 : 0;
    end else begin
      res  = ua - ub;
      sres = sa - sb;
      e_c  = (ua >= ub) ? 1 : 0;
    end
    e_s = ((res % M) + M) % M;
    e_o = (sres < -(M/2) || sres > M/2 - 1) ? 1 : 0;
    e_z = (e_s == 0) ? 1 : 0;
    e_n = (e_s >= M/2) ? 1 : 0;
    if (r) begin
      e_s = 0; e_c = 0; e_o = 0; e_z = 1; e_n = 0;
    end
    rst         = r;
    bus.sel     = s;
    bus.input_a = W'(ua);
    bus.input_b = W'(ub);
    @(posedge clk);
    #1;
    chk($sformatf("s r%0d sel%0d %0d,%0d", r, s, ua, ub), int'(bus.output_s), e_s);
    chk("carry", int'(bus.carry), e_c);
    chk("ovf",   int'(bus.ovf),   e_o);
    chk("zero",  int'(bus.zero),  e_z);
    chk("neg",   int'(bus.neg),   e_n);
  endtask

  initial begin
    // Directed cases
    op(1'b1, OP_ADD, 3, 1);
    op(1'b0, OP_ADD, 3, 1);
    op(1'b0, OP_ADD, 15, 2);
    op(1'b0, OP_ADD, 7, 1);
    op(1'b0, OP_SUB, 7, 3);
    op(1'b0, OP_SUB, 5, 5);
    op(1'b0, OP_SUB, 7, 8);
    op(1'b0, OP_SUB, 0, 1);
    op(1'b0, OP_ADD, 8, 8);
    op(1'b0, OP_SUB, 8, 1);
    // Alternating sel with a one-cycle reset pulse mid-stream
    for (int i = 0; i < 12; i++)
      op(i == 6, i[0], $urandom_range(M-1), $urandom_range(M-1));
    // Random stream with occasional reset
    for (int i = 0; i < 400; i++)
      op($urandom_range(19) == 0, 1'($urandom), $urandom_range(M-1), $urandom_range(M-1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ula.md
# ula

Registered two's-complement add/subtract unit for the datapath. It computes `input_a + input_b` or `input_a - input_b` as selected by `sel`, and registers the WIDTH-bit result plus status flags on the rising clock edge. It is a leaf arithmetic block, fed directly by operand registers and consumed by downstream datapath and flag logic.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range ≥ 2.
- One clock; reset is synchronous and active-high.
- `clk`  input  1  rising-edge clock; all state updates on this edge.
- `rst`  input  1  synchronous active-high reset.
- `sel`  input  1  operation select: 0 = add, 1 = subtract.
- `input_a`  input  WIDTH  operand A.
- `input_b`  input  WIDTH  operand B.
- `output_s`  output  WIDTH  registered result, modulo 2^WIDTH.
- `carry`  output  1  registered carry out of the WIDTH-bit adder.
- `ovf`  output  1  registered two's-complement signed overflow.
- `zero`  output  1  registered flag, high when the result is all zeros.
- `neg`  output  1  registered MSB of the result.

## Operation
- Add (`sel`=0): sum = input_a + input_b + 0.
- Subtract (`sel`=1): sum = input_a + ~input_b + 1.
- Both operations use one shared adder: B is inverted by `sel` and `sel` is the carry-in.
- `output_s` = sum[WIDTH-1:0]. The result wraps silently: 15+2 gives 1, and 7-8 gives 15 (−1).
- `carry`: bit WIDTH of the (WIDTH+1)-bit sum.
  - For add, this is the unsigned carry out.
  - For subtract, carry=1 means no borrow (A ≥ B unsigned).
- `ovf`: asserted when both adder operand MSBs are equal and the result MSB differs from them. The adder operands are A and B for add, and A and ~B for subtract.
- `zero` = (output_s == 0).
- `neg` = output_s[WIDTH-1].
- Operands are treated as both unsigned and two's-complement; the flags cover both interpretations.
- There is no handshake. Every cycle is a new operation.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on all outputs after edge N, stable until edge N+1.
- Throughput is one operation per cycle. Back-to-back changes to `sel` or the operands take effect cycle by cycle.
- Reset: when `rst`=1 at a rising edge, `output_s`=0, `carry`=0, `ovf`=0, `neg`=0 and `zero`=1 after that edge. Inputs are ignored on that edge.
- Deasserting `rst` resumes normal operation at the next edge. There is no other state.
- Before the first edge, outputs are undefined. Benches must apply reset first.

## Structure
- Package `ula_pkg`: constants `OP_ADD = 1'b0` and `OP_SUB = 1'b1`.
- Combinational sub-module `ula_addsub_core`, parameterised by WIDTH.
  - Inputs: a, b, sel.
  - Outputs: sum, carry, ovf.
- Top `ula` instantiates the core, derives `zero`/`neg`, and holds the output register with synchronous reset.

## Test plan
- Reset: assert `rst` with a=3, b=1 → after edge `output_s`=0, `zero`=1, all other flags 0.
- Add: sel=0, a=3, b=1 → `output_s`=4, carry=0, ovf=0, zero=0, neg=0, one cycle later.
- Add wrap: sel=0, a=15, b=2 → `output_s`=1, carry=1, ovf=0. Then a=7, b=1 → `output_s`=8, ovf=1, neg=1.
- Subtract: sel=1, a=7, b=3 → `output_s`=4, carry=1, ovf=0. Then a=5, b=5 → `output_s`=0, zero=1, carry=1.
- Subtract signed overflow: sel=1, a=7, b=8 → `output_s`=15, carry=0, ovf=1, neg=1.
- Back-to-back ops with mid-stream reset: alternate sel each cycle → each result appears exactly one cycle after its inputs. `rst` pulsed for one cycle mid-stream → that cycle's output is 0 with zero=1, and the next result is correct.
